// File: rtl/tx_fifo_mem.sv
// rtl/tx_fifo_mem.sv - single-clock transmit FIFO with registered read port and sticky error flags
//
// Purpose: circular buffer of DEPTH x DATA_WIDTH words with one-cycle read
//          latency, occupancy count, level flags and sticky overflow/underflow.
//
// Ports:
//    clk          - single clock, all state updates on the rising edge
//    reset        - synchronous active-high reset, overrides every other input
//    wr_en        - write request
//    wr_data      - write word
//    rd_en        - read request
//    flush        - synchronous empty command, wins over wr_en/rd_en
//    flag_clr     - clears overflow/underflow
//    rd_data      - registered read word, holds when no read is accepted
//    rd_valid     - registered, high the cycle after an accepted read
//    full         - count == DEPTH
//    empty        - count == 0
//    almost_full  - count >= AFULL_LEVEL
//    count        - occupancy 0..DEPTH
//    overflow     - sticky, a write was rejected
//    underflow    - sticky, a read was rejected

module tx_fifo_mem #(
   parameter int DATA_WIDTH  = 32,
   parameter int ADDR_WIDTH  = 4,
   parameter int AFULL_LEVEL = 12
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  wr_en,
   input  logic [DATA_WIDTH-1:0] wr_data,
   input  logic                  rd_en,
   input  logic                  flush,
   input  logic                  flag_clr,
   output logic [DATA_WIDTH-1:0] rd_data,
   output logic                  rd_valid,
   output logic                  full,
   output logic                  empty,
   output logic                  almost_full,
   output logic [ADDR_WIDTH:0]   count,
   output logic                  overflow,
   output logic                  underflow
);

   localparam int DEPTH = 2 ** ADDR_WIDTH;
   localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH + 1)'(DEPTH);
   localparam logic [ADDR_WIDTH:0] AFULL_C = (ADDR_WIDTH + 1)'(AFULL_LEVEL);

   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [ADDR_WIDTH-1:0] wp;
   logic [ADDR_WIDTH-1:0] rp;
   logic                  rd_acc;
   logic                  wr_acc;

   assign full        = (count == DEPTH_C);
   assign empty       = (count == '0);
   assign almost_full = (count >= AFULL_C);

   // No bypass: a read is only accepted from a non-empty buffer. A write into
   // a full buffer is accepted only when a read frees a slot in the same cycle.
   // Flush blocks both so nothing moves in the cycle the buffer is emptied.
   assign rd_acc = rd_en && !empty && !flush;
   assign wr_acc = wr_en && (!full || rd_acc) && !flush;

   // Storage is deliberately left out of reset/flush; the count guarantees
   // stale locations are never read.
   always_ff @(posedge clk) begin
      if (!reset && wr_acc) begin
         mem[wp] <= wr_data;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wp        <= '0;
         rp        <= '0;
         count     <= '0;
         rd_data   <= '0;
         rd_valid  <= 1'b0;
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else if (flush) begin
         // rd_data and the sticky flags are intentionally preserved
         wp       <= '0;
         rp       <= '0;
         count    <= '0;
         rd_valid <= 1'b0;
      end else begin
         rd_valid <= rd_acc;
         if (wr_acc) begin
            wp <= wp + 1'b1;   // natural wrap at DEPTH-1
         end
         if (rd_acc) begin
            rd_data <= mem[rp];
            rp      <= rp + 1'b1;
         end
         case ({wr_acc, rd_acc})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
         // A new error in the same cycle as flag_clr wins so it is not lost
         if (wr_en && !wr_acc) begin
            overflow <= 1'b1;
         end else if (flag_clr) begin
            overflow <= 1'b0;
         end
         if (rd_en && !rd_acc) begin
            underflow <= 1'b1;
         end else if (flag_clr) begin
            underflow <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_tx_fifo_mem.sv
// tb/tb_tx_fifo_mem.sv - directed self-checking bench for tx_fifo_mem
//
// Purpose: applies directed vectors and compares outputs against
//          hand-computed expectations one cycle after each edge.
//
// Ports: none (top-level bench).

module tb_tx_fifo_mem;

   logic        clk;
   logic        reset;
   logic        wr_en;
   logic [31:0] wr_data;
   logic        rd_en;
   logic        flush;
   logic        flag_clr;
   logic [31:0] rd_data;
   logic        rd_valid;
   logic        full;
   logic        empty;
   logic        almost_full;
   logic [4:0]  count;
   logic        overflow;
   logic        underflow;

   int vectors;
   int miscompares;

   tx_fifo_mem #(
      .DATA_WIDTH (32),
      .ADDR_WIDTH (4),
      .AFULL_LEVEL(12)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .wr_en      (wr_en),
      .wr_data    (wr_data),
      .rd_en      (rd_en),
      .flush      (flush),
      .flag_clr   (flag_clr),
      .rd_data    (rd_data),
      .rd_valid   (rd_valid),
      .full       (full),
      .empty      (empty),
      .almost_full(almost_full),
      .count      (count),
      .overflow   (overflow),
      .underflow  (underflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      if (obs !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Drive one cycle of inputs, clock, then return #1 after the edge with
   // inputs back to idle so checks see the post-edge state.
   task automatic step(input logic rst, input logic we, input logic [31:0] wd,
                       input logic re, input logic fl, input logic fc);
      reset    = rst;
      wr_en    = we;
      wr_data  = wd;
      rd_en    = re;
      flush    = fl;
      flag_clr = fc;
      @(posedge clk);
      #1;
      reset    = 1'b0;
      wr_en    = 1'b0;
      rd_en    = 1'b0;
      flush    = 1'b0;
      flag_clr = 1'b0;
   endtask

   task automatic check_reset_state(input string tag);
      check({tag, "_count"},     32'(count),       32'd0);
      check({tag, "_empty"},     32'(empty),       32'd1);
      check({tag, "_full"},      32'(full),        32'd0);
      check({tag, "_afull"},     32'(almost_full), 32'd0);
      check({tag, "_rd_valid"},  32'(rd_valid),    32'd0);
      check({tag, "_rd_data"},   rd_data,          32'd0);
      check({tag, "_overflow"},  32'(overflow),    32'd0);
      check({tag, "_underflow"}, 32'(underflow),   32'd0);
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      reset = 1'b0; wr_en = 1'b0; wr_data = '0; rd_en = 1'b0; flush = 1'b0; flag_clr = 1'b0;
      #2;

      // Reset state
      step(1, 0, 0, 0, 0, 0);
      step(1, 0, 0, 0, 0, 0);
      check_reset_state("rst");

      // Three writes then three reads, one cycle latency each
      step(0, 1, 32'h11, 0, 0, 0);
      step(0, 1, 32'h22, 0, 0, 0);
      step(0, 1, 32'h33, 0, 0, 0);
      check("wr3_count", 32'(count), 32'd3);
      step(0, 0, 0, 1, 0, 0);
      check("rd1_valid", 32'(rd_valid), 32'd1);
      check("rd1_data",  rd_data, 32'h11);
      step(0, 0, 0, 1, 0, 0);
      check("rd2_valid", 32'(rd_valid), 32'd1);
      check("rd2_data",  rd_data, 32'h22);
      step(0, 0, 0, 1, 0, 0);
      check("rd3_valid", 32'(rd_valid), 32'd1);
      check("rd3_data",  rd_data, 32'h33);
      check("rd3_empty", 32'(empty), 32'd1);
      step(0, 0, 0, 0, 0, 0);
      check("idle_valid", 32'(rd_valid), 32'd0);
      check("idle_hold",  rd_data, 32'h33);

      // Fill to 16, watch almost_full and full thresholds
      for (int i = 0; i < 16; i++) begin
         step(0, 1, 32'h100 + 32'(i), 0, 0, 0);
         check($sformatf("fill%0d_count", i), 32'(count), 32'(i + 1));
         check($sformatf("fill%0d_afull", i), 32'(almost_full), (i + 1 >= 12) ? 32'd1 : 32'd0);
         check($sformatf("fill%0d_full", i),  32'(full),        (i + 1 == 16) ? 32'd1 : 32'd0);
      end
      check("fill_overflow_clear", 32'(overflow), 32'd0);
      step(0, 1, 32'hDEAD, 0, 0, 0);
      check("ovf_flag",  32'(overflow), 32'd1);
      check("ovf_count", 32'(count), 32'd16);

      // Simultaneous read/write while full, then drain to see wrap
      step(0, 1, 32'hAA, 1, 0, 0);
      check("fullrw_count", 32'(count), 32'd16);
      check("fullrw_data",  rd_data, 32'h100);
      check("fullrw_valid", 32'(rd_valid), 32'd1);
      for (int i = 1; i < 16; i++) begin
         step(0, 0, 0, 1, 0, 0);
         check($sformatf("drain%0d_data", i), rd_data, 32'h100 + 32'(i));
      end
      step(0, 0, 0, 1, 0, 0);
      check("drain_last_aa", rd_data, 32'hAA);
      check("drain_empty",   32'(empty), 32'd1);

      // Underflow, no-bypass, flag clearing
      step(0, 0, 0, 1, 0, 0);
      check("unf_flag",  32'(underflow), 32'd1);
      check("unf_valid", 32'(rd_valid), 32'd0);
      step(0, 1, 32'h77, 1, 0, 0);
      check("nobyp_count", 32'(count), 32'd1);
      check("nobyp_valid", 32'(rd_valid), 32'd0);
      step(0, 0, 0, 0, 0, 1);
      check("clr_underflow", 32'(underflow), 32'd0);
      check("clr_overflow",  32'(overflow), 32'd0);
      step(0, 0, 0, 1, 0, 0);
      check("nobyp_data", rd_data, 32'h77);
      step(0, 0, 0, 1, 0, 1);
      check("setclr_underflow", 32'(underflow), 32'd1);
      step(0, 0, 0, 0, 0, 1);
      check("clr2_underflow", 32'(underflow), 32'd0);

      // Flush with a concurrent write at count 5
      for (int i = 0; i < 5; i++) step(0, 1, 32'h200 + 32'(i), 0, 0, 0);
      check("pre_flush_count", 32'(count), 32'd5);
      step(0, 1, 32'h99, 0, 1, 0);
      check("flush_count", 32'(count), 32'd0);
      check("flush_empty", 32'(empty), 32'd1);
      check("flush_ovf",   32'(overflow), 32'd0);
      step(0, 1, 32'h5A, 0, 0, 0);
      step(0, 0, 0, 1, 0, 0);
      check("postflush_data",  rd_data, 32'h5A);
      check("postflush_valid", 32'(rd_valid), 32'd1);
      check("postflush_count", 32'(count), 32'd0);

      // Flush in the cycle after a read kills rd_valid, keeps rd_data
      step(0, 1, 32'h61, 0, 0, 0);
      step(0, 1, 32'h62, 0, 0, 0);
      step(0, 0, 0, 1, 0, 0);
      check("prefl_data", rd_data, 32'h61);
      step(0, 0, 0, 1, 1, 0);
      check("flrd_valid", 32'(rd_valid), 32'd0);
      check("flrd_data",  rd_data, 32'h61);
      check("flrd_count", 32'(count), 32'd0);

      // Reset mid read burst at count 7 with overflow set
      for (int i = 0; i < 17; i++) step(0, 1, 32'h300 + 32'(i), 0, 0, 0);
      check("burst_ovf", 32'(overflow), 32'd1);
      for (int i = 0; i < 9; i++) step(0, 0, 0, 1, 0, 0);
      check("burst_count", 32'(count), 32'd7);
      check("burst_data",  rd_data, 32'h308);
      rd_en = 1'b1;
      step(1, 1, 32'hBEEF, 1, 1, 1);
      check_reset_state("midrst");

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/tx_fifo_mem.md
TX_FIFO_MEM -- requirements
Module: tx_fifo_mem

Interface
REQ-001 Parameter DATA_WIDTH, default 32, sets the width of the data word.
REQ-002 Parameter ADDR_WIDTH, default 4, sets the width of the pointers; DEPTH = 2**ADDR_WIDTH entries.
REQ-003 Parameter AFULL_LEVEL, default 12, sets the occupancy at or above which almost_full asserts; legal range 1..DEPTH.
REQ-004 Port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 Port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 Port wr_en, input, 1 bit: write request.
REQ-007 Port wr_data, input, DATA_WIDTH bits: write word.
REQ-008 Port rd_en, input, 1 bit: read request.
REQ-009 Port flush, input, 1 bit: synchronous empty command.
REQ-010 Port flag_clr, input, 1 bit: clears the sticky error flags.
REQ-011 Port rd_data, output, DATA_WIDTH bits, registered: read word.
REQ-012 Port rd_valid, output, 1 bit, registered: rd_data holds a newly read word.
REQ-013 Port full, output, 1 bit; port empty, output, 1 bit.
REQ-014 Port almost_full, output, 1 bit.
REQ-015 Port count, output, ADDR_WIDTH+1 bits: current occupancy, 0..DEPTH.
REQ-016 Port overflow, output, 1 bit, sticky: a write was rejected.
REQ-017 Port underflow, output, 1 bit, sticky: a read was rejected.

Function
REQ-018 The block SHALL be a circular buffer of DEPTH x DATA_WIDTH storage, with write pointer wp, read pointer rp and the occupancy counter count.
REQ-019 A write SHALL be accepted when wr_en=1 and either full=0, or full=1 and an accepted read occurs in the same cycle: mem[wp] <= wr_data, wp increments.
REQ-020 A read SHALL be accepted when rd_en=1 and empty=0: rd_data <= mem[rp], rp increments, rd_valid=1 in the next cycle.
REQ-021 Read latency SHALL be exactly 1 cycle; rd_valid SHALL be 0 in any cycle that follows a cycle with no accepted read.
REQ-022 rd_data SHALL hold its last value when no read is accepted.
REQ-023 Pointers SHALL wrap from DEPTH-1 to 0.
REQ-024 count SHALL update as follows: +1 on a write only, -1 on a read only, unchanged when both are accepted together.
REQ-025 full = (count == DEPTH); empty = (count == 0); almost_full = (count >= AFULL_LEVEL). All three SHALL be derived combinationally from count.
REQ-026 When empty=1 and both wr_en and rd_en are 1, only the write SHALL be accepted (no bypass); the read is rejected.
REQ-027 overflow SHALL set on any cycle with wr_en=1 whose write is rejected. underflow SHALL set on any cycle with rd_en=1 whose read is rejected.
REQ-028 overflow and underflow SHALL stay set until flag_clr=1 or reset. If a set condition and flag_clr occur in the same cycle, the flag SHALL be set.
REQ-029 flush=1 SHALL set wp=rp=count=0 and rd_valid=0 at the next edge, and SHALL take priority over wr_en and rd_en in that cycle. Storage contents, rd_data and the sticky flags are unchanged.
REQ-030 Storage SHALL NOT be cleared by reset or flush; unwritten locations are never readable because of REQ-020.

Reset
REQ-031 While reset=1 at a clock edge: wp=0, rp=0, count=0, rd_data=0, rd_valid=0, overflow=0, underflow=0; outputs follow, so empty=1, full=0 and almost_full=0.
REQ-032 Reset SHALL override flush, flag_clr, wr_en and rd_en, including when asserted in the middle of a burst.

Verification
REQ-033 Reset, then write 0x11,0x22,0x33 and read 3 -> rd_data 0x11,0x22,0x33, each 1 cycle after its rd_en, rd_valid high 3 cycles, empty=1 at end.
REQ-034 Write 16 words (defaults) -> almost_full rises when count reaches 12, full=1 at count 16. A 17th write -> overflow=1, count stays 16, data unchanged.
REQ-035 When full, wr_en=rd_en=1 with wr_data 0xAA -> count stays 16, oldest word is output, 0xAA is read out last after 15 more reads (wrap verified).
REQ-036 When empty, rd_en=1 -> underflow=1, rd_valid=0. When empty, wr_en=rd_en=1 -> count=1, rd_valid=0. Then flag_clr=1 -> underflow=0.
REQ-037 At count=5, flush=1 together with wr_en=1 -> count=0, empty=1, no write. Then write 0x5A and read it -> rd_data=0x5A.
REQ-038 At count=7, with overflow set, assert reset for 1 cycle during a read burst -> all outputs take the REQ-031 values on the next cycle.
